// File: rtl/sign_printer_pkg.sv
// lcd_printer_pkg: shared FSM state type, default geometry constants and a counter-width helper. Rev 1.0
`default_nettype none

package lcd_printer_pkg;

  localparam int C_ADDR_WIDTH  = 7;
  localparam int C_SIGN_W      = 16;
  localparam int C_SIGN_H      = 8;
  localparam int C_X_WIDTH     = 9;
  localparam int C_Y_WIDTH     = 9;
  localparam int C_COLOR_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A one-deep dimension still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sign_printer_if.sv
// sign_printer_if: start/ROM/pixel-write bundle between the sign printer (master) and its environment (slave). Rev 1.0
`default_nettype none

interface sign_printer_if #(
  parameter int ADDR_WIDTH  = 7,
  parameter int X_WIDTH     = 9,
  parameter int Y_WIDTH     = 9,
  parameter int COLOR_WIDTH = 16
) ();

  logic                   start;
  logic [X_WIDTH-1:0]     x0;
  logic [Y_WIDTH-1:0]     y0;
  logic [COLOR_WIDTH-1:0] fg_color;
  logic [COLOR_WIDTH-1:0] bg_color;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic                   rom_data;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [X_WIDTH-1:0]     pix_x;
  logic [Y_WIDTH-1:0]     pix_y;
  logic [COLOR_WIDTH-1:0] pix_color;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, x0, y0, fg_color, bg_color, rom_data, pix_ready,
    output rom_addr, pix_valid, pix_x, pix_y, pix_color, busy, done
  );

  modport slave (
    output start, x0, y0, fg_color, bg_color, rom_data, pix_ready,
    input  rom_addr, pix_valid, pix_x, pix_y, pix_color, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/sign_printer_pos_counter.sv
// sign_pos_counter: row-major column/row walker over the sign bitmap, with a last-position flag. Rev 1.0
`default_nettype none

module sign_pos_counter #(
  parameter int SIGN_W = 16,
  parameter int SIGN_H = 8,
  parameter int COL_W  = 4,
  parameter int ROW_W  = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear_i,
  input  wire logic             incr_i,
  output logic [COL_W-1:0]      col_o,
  output logic [ROW_W-1:0]      row_o,
  output logic                  last_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_end, row_end;

  assign col_end = (col_q == COL_W'(SIGN_W - 1));
  assign row_end = (row_q == ROW_W'(SIGN_H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (incr_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_end && row_end;

endmodule

`default_nettype wire

// File: rtl/sign_printer.sv
// sign_printer: walks a SIGN_W x SIGN_H ROM bitmap and issues one pixel write per bit. Rev 1.0
// Build option SIGN_TRANSPARENT_EN: clear bits are skipped instead of painted with bg_color.
`default_nettype none

module sign_printer
  import lcd_printer_pkg::*;
#(
  parameter int ADDR_WIDTH  = C_ADDR_WIDTH,
  parameter int SIGN_W      = C_SIGN_W,
  parameter int SIGN_H      = C_SIGN_H,
  parameter int X_WIDTH     = C_X_WIDTH,
  parameter int Y_WIDTH     = C_Y_WIDTH,
  parameter int COLOR_WIDTH = C_COLOR_WIDTH
) (
  input  wire logic     clk,
  input  wire logic     rst,
  sign_printer_if.master bus
);

  localparam int COL_W = cnt_w(SIGN_W);
  localparam int ROW_W = cnt_w(SIGN_H);

  state_t                 state_q;
  logic [X_WIDTH-1:0]     x0_q, pix_x_q, pix_x_d;
  logic [Y_WIDTH-1:0]     y0_q, pix_y_q, pix_y_d;
  logic [COLOR_WIDTH-1:0] fg_q, pix_color_q, pix_color_d;
  logic                   pix_valid_q, busy_q, done_q;
  logic                   emit_px;
  logic                   cnt_clear, cnt_incr;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   last;

  sign_pos_counter #(
    .SIGN_W (SIGN_W),
    .SIGN_H (SIGN_H),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cnt_clear),
    .incr_i  (cnt_incr),
    .col_o   (col),
    .row_o   (row),
    .last_o  (last)
  );

`ifdef SIGN_TRANSPARENT_EN
  assign emit_px     = bus.rom_data;
  assign pix_color_d = fg_q;
`else
  logic [COLOR_WIDTH-1:0] bg_q;
  assign emit_px     = 1'b1;
  assign pix_color_d = bus.rom_data ? fg_q : bg_q;
`endif

  assign pix_x_d = x0_q + X_WIDTH'(col);
  assign pix_y_d = y0_q + Y_WIDTH'(row);

  // Transparent FETCH steps past a clear bit without visiting EMIT.
  assign cnt_clear = (state_q == S_IDLE) && bus.start;
  assign cnt_incr  = ((state_q == S_EMIT)  && bus.pix_ready && !last) ||
                     ((state_q == S_FETCH) && !emit_px      && !last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      fg_q        <= '0;
`ifndef SIGN_TRANSPARENT_EN
      bg_q        <= '0;
`endif
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x0_q    <= bus.x0;
            y0_q    <= bus.y0;
            fg_q    <= bus.fg_color;
`ifndef SIGN_TRANSPARENT_EN
            bg_q    <= bus.bg_color;
`endif
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (emit_px) begin
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            pix_valid_q <= 1'b1;
            state_q     <= S_EMIT;
          end else if (last) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_EMIT: begin
          if (bus.pix_ready) begin
            pix_valid_q <= 1'b0;
            if (last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = ADDR_WIDTH'(int'(row) * SIGN_W + int'(col));
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_color = pix_color_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sign_printer.sv
// tb_sign_printer: directed scenarios with a pixel scoreboard for sign_printer (16x8 sign, 9-bit coords). Rev 1.0
`default_nettype none

module tb_sign_printer;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] c;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   err = 0;
  int   chk = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   first_cyc = -1;
  int   pix_cnt = 0;
  int   t0 = 0;
  int   rom_mode = 0;
  logic [8:0] last_x = '0;
  logic [8:0] last_y = '0;
  px_t  exp_q[$];
  px_t  e_px;
  logic got_exp;

  sign_printer_if #(.ADDR_WIDTH(7), .X_WIDTH(9), .Y_WIDTH(9), .COLOR_WIDTH(16)) bus ();

  sign_printer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sign ROM: address is row*16+col; mode 0 all ones, mode 1 checkerboard set on even row+col.
  function automatic logic rom_bit(input int mode, input int r, input int c);
    return (mode == 0) ? 1'b1 : (((r + c) % 2) == 0);
  endfunction

  always_comb bus.rom_data = rom_bit(rom_mode, int'(bus.rom_addr) / 16, int'(bus.rom_addr) % 16);

  always @(negedge clk) begin
    if (!rst && bus.pix_valid && bus.pix_ready) begin
      pix_cnt++;
      last_x = bus.pix_x;
      last_y = bus.pix_y;
      if (first_cyc < 0) first_cyc = cyc - t0;
      got_exp = (exp_q.size() != 0);
      e_px    = got_exp ? exp_q.pop_front() : '0;
      chk++;
      assert (got_exp && ({bus.pix_x, bus.pix_y, bus.pix_color} === e_px)) else begin
        err++;
        $error("FAIL pixel: observed x=%0d y=%0d c=%h expected x=%0d y=%0d c=%h (expected present=%0b)",
               bus.pix_x, bus.pix_y, bus.pix_color, e_px.x, e_px.y, e_px.c, got_exp);
      end
    end
    if (!rst && bus.done) begin
      done_cnt++;
      done_cyc = cyc - t0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk++;
    assert (obs === expv) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_sign(input int x, input int y, input logic [15:0] fg, input logic [15:0] bg);
    px_t p;
    logic b;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        b = rom_bit(rom_mode, r, c);
`ifdef SIGN_TRANSPARENT_EN
        if (!b) continue;
`endif
        p.x = 9'((x + c) % 512);
        p.y = 9'((y + r) % 512);
        p.c = b ? fg : bg;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic start_sign(input int x, input int y, input logic [15:0] fg, input logic [15:0] bg);
    @(posedge clk); #1;
    bus.x0       = 9'(x);
    bus.y0       = 9'(y);
    bus.fg_color = fg;
    bus.bg_color = bg;
    bus.start    = 1'b1;
    t0           = cyc;
    first_cyc    = -1;
    pix_cnt      = 0;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_cnt == base && n < 600) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 64'(done_cnt), 64'(base + 1));
  endtask

  initial begin
    int d;
    bus.start     = 1'b0;
    bus.x0        = '0;
    bus.y0        = '0;
    bus.fg_color  = '0;
    bus.bg_color  = '0;
    bus.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.pix_valid), 64'd0);
    check("rst_busy",  64'(bus.busy),      64'd0);
    check("rst_done",  64'(bus.done),      64'd0);
    check("rst_addr",  64'(bus.rom_addr),  64'd0);
    check("rst_payload", {28'd0, bus.pix_x, bus.pix_y, bus.pix_color}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pix_ready = 1'b1;

    // All-ones sign at (10,20)
    rom_mode = 0;
    d = done_cnt;
    push_sign(10, 20, 16'hF800, 16'h001F);
    start_sign(10, 20, 16'hF800, 16'h001F);
    wait_done(d, "s1_done_seen");
    check("s1_first_latency", 64'(first_cyc), 64'd2);
    check("s1_done_latency",  64'(done_cyc),  64'd257);
    check("s1_pix_count",     64'(pix_cnt),   64'd128);
    check("s1_last_xy",       {46'd0, last_x, last_y}, {46'd0, 9'd25, 9'd27});
    check("s1_queue_empty",   64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("s1_idle_busy",     64'(bus.busy), 64'd0);

    // Checkerboard sign
    rom_mode = 1;
    d = done_cnt;
    push_sign(0, 0, 16'hF800, 16'h001F);
    start_sign(0, 0, 16'hF800, 16'h001F);
    wait_done(d, "s2_done_seen");
`ifdef SIGN_TRANSPARENT_EN
    check("s2_pix_count", 64'(pix_cnt), 64'd64);
`else
    check("s2_pix_count", 64'(pix_cnt), 64'd128);
`endif
    check("s2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure on the 3rd pixel for 5 cycles
    rom_mode = 0;
    d = done_cnt;
    push_sign(30, 40, 16'h07E0, 16'h0000);
    start_sign(30, 40, 16'h07E0, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s3_stall_valid",   64'(bus.pix_valid), 64'd1);
      check("s3_stall_payload", {28'd0, bus.pix_x, bus.pix_y, bus.pix_color},
                                {28'd0, 9'd32, 9'd40, 16'h07E0});
    end
    @(posedge clk); #1;
    bus.pix_ready = 1'b1;
    wait_done(d, "s3_done_seen");
    check("s3_done_latency", 64'(done_cyc), 64'd262);
    check("s3_pix_count",    64'(pix_cnt),  64'd128);
    check("s3_queue_empty",  64'(exp_q.size()), 64'd0);

    // Coordinate wrap
    d = done_cnt;
    push_sign(500, 508, 16'hFFFF, 16'h0000);
    start_sign(500, 508, 16'hFFFF, 16'h0000);
    wait_done(d, "s4_done_seen");
    check("s4_last_xy",     {46'd0, last_x, last_y}, {46'd0, 9'd3, 9'd3});
    check("s4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start while busy and start in the done cycle are both ignored
    d = done_cnt;
    push_sign(0, 0, 16'h001F, 16'hF800);
    start_sign(0, 0, 16'h001F, 16'hF800);
    repeat (49) @(posedge clk);
    #1;
    bus.x0 = 9'd100; bus.y0 = 9'd100; bus.fg_color = 16'h1234; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (206) @(posedge clk);
    #1;
    bus.x0 = 9'd200; bus.y0 = 9'd200; bus.start = 1'b1;
    @(negedge clk);
    check("s5_done_in_cycle_257", 64'(bus.done), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("s5_busy_after_done", 64'(bus.busy), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("s5_one_done",     64'(done_cnt), 64'(d + 1));
    check("s5_pix_count",    64'(pix_cnt),  64'd128);
    check("s5_queue_empty",  64'(exp_q.size()), 64'd0);

    // Reset on the 40th pixel, then restart
    push_sign(10, 20, 16'hF800, 16'h001F);
    start_sign(10, 20, 16'hF800, 16'h001F);
    repeat (79) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("s6_valid_at_40th", 64'(bus.pix_valid), 64'd1);
    check("s6_pixels_before", 64'(pix_cnt), 64'd39);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("s6_valid_after_rst", 64'(bus.pix_valid), 64'd0);
    check("s6_busy_after_rst",  64'(bus.busy), 64'd0);
    check("s6_remaining",       64'(exp_q.size()), 64'd89);
    exp_q.delete();
    d = done_cnt;
    push_sign(50, 60, 16'hABCD, 16'h0000);
    start_sign(50, 60, 16'hABCD, 16'h0000);
    @(negedge clk);
    check("s6_restart_addr", 64'(bus.rom_addr), 64'd0);
    wait_done(d, "s6_done_seen");
    check("s6_first_latency", 64'(first_cyc), 64'd2);
    check("s6_queue_empty",   64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
